mesh_row_sorter: RTL
====================

MESH_ROW_SORTER -- requirements
Module: mesh_row_sorter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: width of the packet address (sort key) field.
REQ-002 SHALL have parameter DATA_WIDTH, default 6: width of the packet payload field.
REQ-003 SHALL have parameter LEN, default 4: number of slots in the row (LEN >= 2).
REQ-004 SHALL derive WIDTH = ADDR_WIDTH + DATA_WIDTH; slot i occupies bits [i*WIDTH +: WIDTH], address in the upper ADDR_WIDTH bits of the slot.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: a row is offered.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a row.
REQ-009 SHALL have port in_data, input, LEN*WIDTH: row packets.
REQ-010 SHALL have port in_mask, input, LEN: bit i = 1 marks slot i as holding a valid packet.
REQ-011 SHALL have port descending, input, 1: sort direction, sampled on accept.
REQ-012 SHALL have port out_valid, output, 1: sorted row available.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the row.
REQ-014 SHALL have port out_data, output, LEN*WIDTH: sorted packets.
REQ-015 SHALL have port out_mask, output, LEN: validity of the sorted slots.
REQ-016 SHALL have port steps_used, output, clog2(LEN+1): number of compare-exchange steps executed.

Function
REQ-017 SHALL implement FSM states IDLE, SORT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-018 In IDLE, in_valid & in_ready SHALL load in_data, in_mask and descending into registers, clear the step counter, and enter SORT.
REQ-019 Each SORT cycle SHALL execute one odd-even transposition step: even steps (0,2,..) compare pairs (0,1),(2,3),..; odd steps compare pairs (1,2),(3,4),..; unpaired edge slots are held.
REQ-020 Compare rule: ascending mode SHALL put the smaller address at the lower index; descending mode the larger; equal addresses SHALL NOT swap (stable).
REQ-021 Invalid slots SHALL always sort toward the highest index in either direction; two invalid slots SHALL NOT swap; the mask bit SHALL move with its packet.
REQ-022 SORT SHALL exit to DONE after the step in which the counter reaches LEN, or earlier once two consecutive steps performed no swap (minimum 2 steps).
REQ-023 steps_used SHALL equal the number of steps executed and SHALL remain stable while in DONE.
REQ-024 Latency from the accept edge to the out_valid assertion SHALL be steps_used+1 cycles; worst case LEN+1.
REQ-025 out_data/out_mask SHALL hold stable in DONE until out_valid & out_ready; the block SHALL then return to IDLE on that edge (in_ready high next cycle).
REQ-026 in_valid SHALL be ignored outside IDLE; descending and in_* changes during SORT SHALL have no effect.
REQ-027 Payload bits of invalid slots SHALL be carried unmodified; out_data is meaningful only where out_mask is set.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, step counter 0, steps_used 0, data/mask registers 0; therefore in_ready=1, out_valid=0, out_data=0, out_mask=0.
REQ-029 rst asserted mid-SORT or mid-DONE SHALL abort the row with no output; the first accept after release SHALL behave as from power-up.

Verification (LEN=4, ADDR_WIDTH=6, DATA_WIDTH=6; addresses listed slot0..slot3)
REQ-030 Reverse row: addr 12,9,6,3, mask 1111, ascending -> out 3,6,9,12, mask 1111, steps_used=4, out_valid 5 cycles after accept.
REQ-031 Presorted row: addr 3,6,9,12, ascending -> unchanged, steps_used=2, out_valid 3 cycles after accept.
REQ-032 Descending: addr 3,6,9,12, descending=1 -> out 12,9,6,3, steps_used=4.
REQ-033 Holes: addr 9,x,3,6, in_mask 4'b1101, ascending -> out 3,6,9 in slots 0-2, out_mask 4'b0111.
REQ-034 Stability/backpressure: slot0 {addr 5,data 1}, slot1 {addr 5,data 2}, out_ready low 10 cycles -> order preserved, out_data stable, in_ready low until the handshake.
REQ-035 Reset mid-sort: rst low during step 2 -> out_valid 0, in_ready 1 immediately; next row sorts correctly with steps_used counted from 0.

Source files
------------

// File: rtl/mesh_row_sorter.sv
// Row sorter for mesh packets: odd-even transposition on address keys,
// with invalid slots sinking to the top index and early exit when quiet.
module mesh_row_sorter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 6,
  parameter int LEN        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LEN*(ADDR_WIDTH+DATA_WIDTH)-1:0]  in_data,
  input  logic [LEN-1:0]                          in_mask,
  input  logic                                    descending,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LEN*(ADDR_WIDTH+DATA_WIDTH)-1:0]  out_data,
  output logic [LEN-1:0]                          out_mask,
  output logic [$clog2(LEN+1)-1:0]                steps_used
);

  localparam int WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW    = $clog2(LEN+1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [LEN*WIDTH-1:0] data_q;
  logic [LEN*WIDTH-1:0] nxt_data;
  logic [LEN-1:0]       mask_q;
  logic [LEN-1:0]       nxt_mask;
  logic                 desc_q;
  logic [SW-1:0]        cnt_q;
  logic [1:0]           quiet_q;
  logic [LEN-2:0]       want;
  logic [LEN-2:0]       act;
  logic                 swapped;
  logic                 finish;

  // Per-pair order test; only pairs matching the step parity act.
  for (genvar i = 0; i < LEN-1; i++) begin : g_cmp
    logic [ADDR_WIDTH-1:0] a_lo;
    logic [ADDR_WIDTH-1:0] a_hi;
    logic                  v_lo;
    logic                  v_hi;
    assign a_lo = data_q[i*WIDTH+DATA_WIDTH +: ADDR_WIDTH];
    assign a_hi = data_q[(i+1)*WIDTH+DATA_WIDTH +: ADDR_WIDTH];
    assign v_lo = mask_q[i];
    assign v_hi = mask_q[i+1];
    assign want[i] = (v_hi & ~v_lo) |
                     (v_lo & v_hi &
                      (desc_q ? (a_hi > a_lo) : (a_lo > a_hi)));
    assign act[i] = want[i] & (cnt_q[0] == 1'(i % 2));
  end

  assign swapped = |act;
  assign finish  = (cnt_q == SW'(LEN)) | (quiet_q == 2'd2);

  // One transposition step: swap active pairs, mask travels along.
  always_comb begin
    nxt_data = data_q;
    nxt_mask = mask_q;
    for (int i = 0; i < LEN-1; i++) begin
      if (act[i]) begin
        nxt_data[i*WIDTH +: WIDTH]     = data_q[(i+1)*WIDTH +: WIDTH];
        nxt_data[(i+1)*WIDTH +: WIDTH] = data_q[i*WIDTH +: WIDTH];
        nxt_mask[i]                    = mask_q[i+1];
        nxt_mask[i+1]                  = mask_q[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_nxt = SORT;
      SORT:    if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Row registers, step counter and quiet-step history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      mask_q  <= '0;
      desc_q  <= 1'b0;
      cnt_q   <= '0;
      quiet_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      data_q  <= in_data;
      mask_q  <= in_mask;
      desc_q  <= descending;
      cnt_q   <= '0;
      quiet_q <= '0;
    end else if (state_q == SORT && !finish) begin
      data_q  <= nxt_data;
      mask_q  <= nxt_mask;
      cnt_q   <= cnt_q + SW'(1);
      quiet_q <= swapped ? 2'd0 : quiet_q + 2'd1;
    end
  end

  assign out_data   = data_q;
  assign out_mask   = mask_q;
  assign steps_used = cnt_q;

endmodule
